// File: rtl/signed_narrow.sv
// signed_narrow: converts a wide signed fixed-point value into a narrow signed
// integer. Stage 1 drops the fraction bits, and stage 2 saturates the headroom
// bits away. Both stages use valid/ready handshakes.
// Build option: define SIGNED_NARROW_ROUND_EN to round half toward +inf.
// Without it, the fraction bits are floored with an arithmetic shift.
module signed_narrow #(
  parameter int ORIGINAL_BITS  = 8,
  parameter int LEADING_BITS   = 8,
  parameter int FOLLOWING_BITS = 4,
  parameter int COUNT_BITS     = 16,
  localparam int W = ORIGINAL_BITS + LEADING_BITS + FOLLOWING_BITS,
  localparam int R = W + 1 - FOLLOWING_BITS
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [W-1:0]             in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [ORIGINAL_BITS-1:0] out_data,
  output logic                     out_sat,
  output logic [COUNT_BITS-1:0]    sat_count,
  input  logic                     sat_clear
);

`ifdef SIGNED_NARROW_ROUND_EN
  localparam logic [W:0] BIAS = (W+1)'(1) << (FOLLOWING_BITS - 1);
`else
  localparam logic [W:0] BIAS = '0;
`endif

  localparam logic [ORIGINAL_BITS-1:0] MAX_VAL = {1'b0, {(ORIGINAL_BITS-1){1'b1}}};
  localparam logic [ORIGINAL_BITS-1:0] MIN_VAL = {1'b1, {(ORIGINAL_BITS-1){1'b0}}};

  logic                     s1_valid_q, s1_valid_d;
  logic [R-1:0]             s1_r_q, s1_r_d;
  logic                     out_valid_q, out_valid_d;
  logic [ORIGINAL_BITS-1:0] out_data_q, out_data_d;
  logic                     out_sat_q, out_sat_d;
  logic [COUNT_BITS-1:0]    sat_count_q, sat_count_d;

  logic [W:0]                biased;
  logic [R-1:0]              round_r;
  logic [FOLLOWING_BITS-1:0] dropped_frac_unused;
  logic [ORIGINAL_BITS-1:0]  sat_data;
  logic                      sat_flag;
  logic                      s2_move;
  logic                      out_fire;

  // Round stage: one extra bit above the sign absorbs the carry that the bias
  // can produce, and taking the top slice of the sum is the arithmetic shift.
  always_comb begin
    biased              = {in_data[W-1], in_data} + BIAS;
    round_r             = biased[W:FOLLOWING_BITS];
    dropped_frac_unused = biased[FOLLOWING_BITS-1:0];
  end

  // Saturate stage: the value fits only when every bit above the narrow sign bit
  // is a copy of that bit. Otherwise the result clamps toward the sign of r.
  always_comb begin
    sat_data = s1_r_q[ORIGINAL_BITS-1:0];
    sat_flag = 1'b0;
    if (!((&s1_r_q[R-1:ORIGINAL_BITS-1]) || !(|s1_r_q[R-1:ORIGINAL_BITS-1]))) begin
      sat_flag = 1'b1;
      sat_data = s1_r_q[R-1] ? MIN_VAL : MAX_VAL;
    end
  end

  // Handshake and next state. Stage 2 advances whenever its slot is empty or is
  // being drained. Stage 1 accepts input whenever it can pass its sample on.
  always_comb begin
    s2_move     = !out_valid_q || out_ready;
    in_ready    = !s1_valid_q || s2_move;
    out_fire    = out_valid_q && out_ready;

    s1_valid_d  = s1_valid_q;
    s1_r_d      = s1_r_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sat_d   = out_sat_q;
    sat_count_d = sat_count_q;

    if (in_ready) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_r_d = round_r;
      end
    end

    if (s2_move) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        out_data_d = sat_data;
        out_sat_d  = sat_flag;
      end
    end

    if (sat_clear) begin
      sat_count_d = '0;
    end else if (out_fire && out_sat_q && !(&sat_count_q)) begin
      sat_count_d = sat_count_q + COUNT_BITS'(1);
    end
  end

  // State registers. Reset discards any samples that are still in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_r_q      <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sat_q   <= 1'b0;
      sat_count_q <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_r_q      <= s1_r_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sat_q   <= out_sat_d;
      sat_count_q <= sat_count_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sat   = out_sat_q;
  assign sat_count = sat_count_q;

endmodule
